// File: rtl/fifo_rd_stream.sv
// Read-side adapter: pops words from a FIFO with one-cycle read latency and
// presents them as a valid/ready stream with burst framing and a beat counter.
module fifo_rd_stream #(
  parameter int unsigned BITWID  = 8,
  parameter int unsigned DEEPWID = 3
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic [DEEPWID:0]  fifo_rd_num,
  output logic              fifo_rd,
  input  logic [BITWID-1:0] fifo_rd_dat,
  input  logic              fifo_rd_dat_vld,
  output logic              m_vld,
  input  logic              m_rdy,
  output logic [BITWID-1:0] m_dat,
  output logic              m_last,
  input  logic [7:0]        cfg_burst_len,
  output logic              err_unexp,
  output logic [15:0]       beat_cnt
);

  logic [BITWID-1:0] mem [3];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [1:0]        occ;
  logic              infl;
  logic [7:0]        pos;
  logic              fill;
  logic              bad;
  logic              accept;
  logic              burst_end;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Read issue only looks at registered occupancy, never at m_rdy, so a full
  // buffer plus one outstanding read can never overflow.
  always_comb begin
    fifo_rd   = !rd_rst && (fifo_rd_num != '0) &&
                (({1'b0, occ} + {2'b0, infl}) < 3'd3);
    m_vld     = (occ != 2'd0);
    m_dat     = mem[rd_ptr];
    burst_end = (cfg_burst_len <= 8'd1) || (pos >= cfg_burst_len - 8'd1);
    m_last    = m_vld && burst_end;
    accept    = m_vld && m_rdy;
    fill      = fifo_rd_dat_vld && infl && (occ != 2'd3);
    bad       = fifo_rd_dat_vld && (!infl || (occ == 2'd3));
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      mem[2]    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      infl      <= 1'b0;
      pos       <= '0;
      err_unexp <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      if (fill) begin
        mem[wr_ptr] <= fifo_rd_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (accept) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        beat_cnt <= beat_cnt + 16'd1;
        pos      <= burst_end ? 8'd0 : pos + 8'd1;
      end
      if (fill && !accept) begin
        occ <= occ + 2'd1;
      end else if (!fill && accept) begin
        occ <= occ - 2'd1;
      end
      if (fifo_rd) begin
        infl <= 1'b1;
      end else if (fill) begin
        infl <= 1'b0;
      end
      if (bad) begin
        err_unexp <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench: an upstream FIFO model feeds the DUT; a monitor checks
// every accepted beat against queued words and the burst framing rule.
module tb_fifo_rd_stream;
  localparam int BW = 8;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          rd_rst;
  logic [DW:0]   fifo_rd_num;
  logic          fifo_rd;
  logic [BW-1:0] fifo_rd_dat;
  logic          fifo_rd_dat_vld;
  logic          m_vld;
  logic          m_rdy;
  logic [BW-1:0] m_dat;
  logic          m_last;
  logic [7:0]    cfg_burst_len;
  logic          err_unexp;
  logic [15:0]   beat_cnt;

  fifo_rd_stream #(.BITWID(BW), .DEEPWID(DW)) dut (
    .rd_clk          (clk),
    .rd_rst          (rd_rst),
    .fifo_rd_num     (fifo_rd_num),
    .fifo_rd         (fifo_rd),
    .fifo_rd_dat     (fifo_rd_dat),
    .fifo_rd_dat_vld (fifo_rd_dat_vld),
    .m_vld           (m_vld),
    .m_rdy           (m_rdy),
    .m_dat           (m_dat),
    .m_last          (m_last),
    .cfg_burst_len   (cfg_burst_len),
    .err_unexp       (err_unexp),
    .beat_cnt        (beat_cnt)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            failures = 0;
  logic [BW-1:0] src_q[$];
  logic [BW-1:0] exp_q[$];
  int            gen_left = 0;
  bit            throttle = 0;
  bit            cfg_rand = 0;
  bit            inject = 0;
  bit            pend = 0;
  logic [BW-1:0] pend_dat;
  int            rdy_mode = 0;
  int            cyc = 0;
  int            rd_pulses = 0;
  int            first_rd = -1;
  int            last_rd = -1;
  int            acc_n = 0;
  int            first_acc = -1;
  int            last_acc = -1;
  int            bpos = 0;
  int            model_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_word();
    logic [BW-1:0] w;
    w = BW'($urandom);
    src_q.push_back(w);
    exp_q.push_back(w);
    gen_left--;
  endtask

  // Upstream FIFO model: one-cycle read latency, count reflects words queued.
  initial begin
    fifo_rd_num     = '0;
    fifo_rd_dat     = '0;
    fifo_rd_dat_vld = 1'b0;
    m_rdy           = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pend && !rd_rst) begin
        fifo_rd_dat_vld = 1'b1;
        fifo_rd_dat     = pend_dat;
      end else if (inject) begin
        fifo_rd_dat_vld = 1'b1;
        fifo_rd_dat     = 8'hEE;
        inject          = 0;
      end else begin
        fifo_rd_dat_vld = 1'b0;
        fifo_rd_dat     = BW'($urandom);
      end
      pend = 0;
      if (throttle) begin
        if (gen_left > 0 && src_q.size() < 15 && $urandom_range(0, 1) == 1) push_word();
      end else begin
        while (gen_left > 0 && src_q.size() < 15) push_word();
      end
      fifo_rd_num = (DW+1)'(src_q.size());
      case (rdy_mode)
        0:       m_rdy = 1'b0;
        1:       m_rdy = 1'b1;
        default: m_rdy = 1'($urandom_range(0, 1));
      endcase
      if (cfg_rand && $urandom_range(0, 30) == 0) cfg_burst_len = 8'($urandom_range(0, 6));
      #1;
      if (fifo_rd_num == '0) chk("rd_when_empty", 32'(fifo_rd), 32'd0);
      if (fifo_rd) begin
        if (src_q.size() != 0) begin
          pend_dat = src_q.pop_front();
          pend     = 1;
        end
        rd_pulses++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
      end
    end
  end

  // Monitor: compares accepted beats to the scoreboard and checks stall hold.
  initial begin : mon
    bit            prev_stall;
    logic [BW-1:0] prev_dat;
    logic [BW-1:0] w;
    bit            el;
    prev_stall = 0;
    prev_dat   = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rd_rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("stall_vld", 32'(m_vld), 32'd1);
          chk("stall_dat", 32'(m_dat), 32'(prev_dat));
        end
        if (m_vld && m_rdy) begin
          chk("beat_cnt_run", 32'(beat_cnt), 32'(model_cnt[15:0]));
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%0h required=no beat", m_dat);
          end else begin
            w  = exp_q.pop_front();
            chk("m_dat", 32'(m_dat), 32'(w));
            el = (cfg_burst_len <= 8'd1) || (bpos >= int'(cfg_burst_len) - 1);
            chk("m_last", 32'(m_last), 32'(el));
            bpos = el ? 0 : bpos + 1;
          end
          model_cnt++;
          acc_n++;
          if (first_acc < 0) first_acc = cyc;
          last_acc = cyc;
        end
        prev_stall = m_vld && !m_rdy;
        prev_dat   = m_dat;
      end
    end
  end

  task automatic clear_phase();
    rd_pulses = 0;
    first_rd  = -1;
    last_rd   = -1;
    acc_n     = 0;
    first_acc = -1;
    last_acc  = -1;
  endtask

  task automatic do_reset(input int n);
    rd_rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    src_q.delete();
    exp_q.delete();
    gen_left  = 0;
    pend      = 0;
    inject    = 0;
    bpos      = 0;
    model_cnt = 0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((gen_left > 0 || exp_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (gen_left > 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout actual=%0d words pending required=0", name, exp_q.size() + gen_left);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_500_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rd_rst        = 1'b1;
    cfg_burst_len = 8'd4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #3;
    chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    chk("rst_m_vld", 32'(m_vld), 32'd0);
    chk("rst_m_dat", 32'(m_dat), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_err", 32'(err_unexp), 32'd0);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);

    // Five-word burst with sink always ready
    @(posedge clk);
    #1;
    rd_rst = 1'b0;
    clear_phase();
    rdy_mode = 1;
    gen_left = 5;
    wait_drain("burst5", 50);
    chk("burst5_rd_pulses", 32'(rd_pulses), 32'd5);
    chk("burst5_rd_span", 32'(last_rd - first_rd), 32'd4);
    chk("burst5_latency", 32'(first_acc - first_rd), 32'd2);
    chk("burst5_acc_span", 32'(last_acc - first_acc), 32'd4);
    chk("burst5_beats", 32'(acc_n), 32'd5);
    chk("burst5_beat_cnt", 32'(beat_cnt), 32'd5);

    // Sink stalled: reads stop once buffer plus in-flight is full
    clear_phase();
    rdy_mode = 0;
    gen_left = 8;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #3;
    chk("stall_rd_pulses", 32'(rd_pulses), 32'd3);
    chk("stall_fifo_rd", 32'(fifo_rd), 32'd0);
    @(posedge clk);
    #1;
    rdy_mode = 1;
    wait_drain("stall8", 100);
    chk("stall8_beats", 32'(acc_n), 32'd8);

    // Random backpressure, sparse supply, burst length changes mid-burst
    clear_phase();
    rdy_mode = 2;
    throttle = 1;
    cfg_rand = 1;
    gen_left = 1000;
    wait_drain("random", 20000);
    throttle      = 0;
    cfg_rand      = 0;
    cfg_burst_len = 8'd4;
    chk("random_beats", 32'(acc_n), 32'd1000);
    chk("random_err", 32'(err_unexp), 32'd0);

    // Unexpected data-valid with no read outstanding and buffer full
    clear_phase();
    rdy_mode = 0;
    gen_left = 3;
    repeat (8) @(posedge clk);
    @(negedge clk);
    #3;
    chk("err_before", 32'(err_unexp), 32'd0);
    chk("full_no_rd", 32'(fifo_rd), 32'd0);
    @(posedge clk);
    #1;
    inject = 1;
    @(negedge clk);
    @(negedge clk);
    #3;
    chk("err_set", 32'(err_unexp), 32'd1);
    repeat (3) @(negedge clk);
    #3;
    chk("err_held", 32'(err_unexp), 32'd1);
    @(posedge clk);
    #1;
    rdy_mode = 1;
    wait_drain("err_drain", 50);
    chk("err_drain_beats", 32'(acc_n), 32'd3);
    chk("err_sticky", 32'(err_unexp), 32'd1);
    do_reset(2);
    @(negedge clk);
    #3;
    chk("err_cleared", 32'(err_unexp), 32'd0);
    @(posedge clk);
    #1;
    rd_rst = 1'b0;

    // Reset with two words buffered and one read in flight
    clear_phase();
    rdy_mode = 0;
    gen_left = 8;
    n = 0;
    while (rd_pulses < 3 && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("midrst_pulses", 32'(rd_pulses), 32'd3);
    @(negedge clk);
    rd_rst = 1'b1;
    #3;
    chk("midrst_vld_before", 32'(m_vld), 32'd1);
    do_reset(1);
    @(negedge clk);
    #3;
    chk("midrst_m_vld", 32'(m_vld), 32'd0);
    chk("midrst_fifo_rd", 32'(fifo_rd), 32'd0);
    chk("midrst_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("midrst_m_dat", 32'(m_dat), 32'd0);
    inject = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rd_rst = 1'b0;
    @(negedge clk);
    #3;
    chk("rst_inject_no_err", 32'(err_unexp), 32'd0);
    @(posedge clk);
    #1;
    clear_phase();
    cfg_burst_len = 8'd3;
    rdy_mode      = 1;
    gen_left      = 7;
    wait_drain("post_rst", 50);
    chk("post_rst_beats", 32'(acc_n), 32'd7);
    chk("post_rst_beat_cnt", 32'(beat_cnt), 32'd7);
    chk("post_rst_err", 32'(err_unexp), 32'd0);

    // Burst lengths 0 and 1: every beat last
    clear_phase();
    cfg_burst_len = 8'd0;
    gen_left      = 5;
    wait_drain("len0", 50);
    cfg_burst_len = 8'd1;
    gen_left      = 5;
    wait_drain("len1", 50);
    chk("len01_beats", 32'(acc_n), 32'd10);

    // Beat counter wrap after 65536 beats from reset
    do_reset(2);
    @(posedge clk);
    #1;
    rd_rst = 1'b0;
    clear_phase();
    cfg_burst_len = 8'd2;
    rdy_mode      = 1;
    gen_left      = 65536;
    wait_drain("wrap", 70000);
    chk("wrap_beats", 32'(acc_n), 32'd65536);
    chk("beat_cnt_wrap", 32'(beat_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
